// File: rtl/reg_bank_writer_pkg.sv
// Shared constants and FSM encoding for the register bank write side.
package reg_bank_writer_pkg;
    localparam int WIDTH = 32;
    localparam int SEL_W = 5;
    localparam int DEPTH = 1 << SEL_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/reg_bank_writer_dec.sv
// Address to one-hot enable decoder, gated by a single enable.
module reg_bank_writer_dec #(
    parameter int SEL_W = 5,
    parameter int DEPTH = 1 << SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] addr,
    output logic [DEPTH-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the register bank: handshaked writes plus a sequenced clear-all,
// one entry per cycle, sharing a single decoder through an address mux.
module reg_bank_writer
    import reg_bank_writer_pkg::*;
#(
    parameter int WIDTH_P   = WIDTH,
    parameter int SEL_W_P   = SEL_W,
    parameter int DEPTH_P   = 1 << SEL_W_P,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [SEL_W_P-1:0]         wr_addr,
    input  logic [WIDTH_P-1:0]         wr_data,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic [WIDTH_P*DEPTH_P-1:0] q
);
    state_t               state, state_nxt;
    logic [SEL_W_P-1:0]   cnt, cnt_nxt;
    logic                 wr_fire;
    logic                 dec_en;
    logic [SEL_W_P-1:0]   dec_addr;
    logic [DEPTH_P-1:0]   dec_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt == SEL_W_P'(DEPTH_P - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_ready = (state == ST_IDLE) && !reset;
    assign clr_busy = (state == ST_CLEAR);
    assign wr_fire  = wr_valid && wr_ready;

    // The clear sweep borrows the write decoder; writes are blocked while it runs.
    assign dec_addr = clr_busy ? cnt : wr_addr;
    assign dec_en   = clr_busy || wr_fire;

    reg_bank_writer_dec #(.SEL_W(SEL_W_P), .DEPTH(DEPTH_P)) u_dec (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (dec_oh)
    );

    for (genvar i = 0; i < DEPTH_P; i++) begin : g_entry
        if (i == 0 && ZERO_REG0) begin : g_zero
            assign q[0 +: WIDTH_P] = '0;
        end else begin : g_reg
            logic [WIDTH_P-1:0] entry;
            always_ff @(posedge clk) begin
                if (reset)          entry <= '0;
                else if (dec_oh[i]) entry <= clr_busy ? '0 : wr_data;
            end
            assign q[i*WIDTH_P +: WIDTH_P] = entry;
        end
    end
endmodule
